fir_xifu_scoreboard: RTL
========================

Name: fir_xifu_scoreboard

Overview:
- Parametrised instruction scoreboard for the FIR XIFU. It generalises the fixed, small tracking in the current controller to NB_SLOTS outstanding XIF instructions and NB_REGS coprocessor registers.
- Tracks, per outstanding instruction: id, destination register, and commit/kill state.
- Gates issue on slot availability, duplicate id, and RAW/WAW register hazards.
- Sits between ID (issue side), the XIF commit interface, EX (commit-state query) and WB (retire).

Parameters:
- NB_SLOTS, 4, number of outstanding instructions tracked (>=2).
- ID_WIDTH, 4, width of XIF instruction id.
- NB_REGS, 4, number of coprocessor registers (>=2). RW = $clog2(NB_REGS).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- clear_i  in  1  synchronous flush: invalidates all slots
- issue_valid_i  in  1  ID offers an instruction
- issue_ready_o  out  1  scoreboard accepts it
- issue_id_i  in  ID_WIDTH  instruction id
- issue_rd_i  in  RW  destination register
- issue_rd_we_i  in  1  instruction writes rd
- issue_rs_i  in  2*RW  source registers {rs1,rs0}
- issue_rs_used_i  in  2  per-source use flags
- commit_valid_i  in  1  XIF commit strobe
- commit_id_i  in  ID_WIDTH  committed id
- commit_kill_i  in  1  commit is a kill
- query_id_i  in  ID_WIDTH  EX asks for state of this id
- query_committed_o  out  1  id present, committed, not killed
- query_killed_o  out  1  id present and killed
- retire_valid_i  in  1  WB retires an instruction
- retire_id_i  in  ID_WIDTH  retired id
- count_o  out  $clog2(NB_SLOTS+1)  occupied slots
- full_o  out  1  count_o==NB_SLOTS
- empty_o  out  1  count_o==0
- err_o  out  1  one-cycle pulse on a protocol error

Behaviour:
- Per-slot state, all registered:
  - valid, id, rd, rd_we.
  - Commit FSM per slot: FREE -> PENDING (on issue) -> COMMITTED or KILLED (on commit) -> FREE (on retire).
- Reset (rst_i) and clear_i:
  - All slots go to FREE on the next edge.
  - Outputs afterwards: count_o=0, empty_o=1, full_o=0, err_o=0, query_*=0.
  - issue_ready_o=1 when no hazard (none exists while empty).
  - clear_i has priority over every same-cycle event.
- issue_ready_o is combinational from registered state and issue inputs. It is 1 iff all of:
  - not full;
  - no valid slot holds issue_id_i;
  - for each used rs, no valid slot with rd_we=1 has rd==rs (RAW);
  - if issue_rd_we_i, no valid slot with rd_we=1 has rd==issue_rd_i (WAW).
- Hazard and full evaluation uses start-of-cycle state. A same-cycle retire does not free a slot or clear a hazard until the next cycle.
- Issue handshake (valid&ready): allocate the lowest-index FREE slot; it becomes PENDING at the next edge.
- Commit: the matching valid slot moves PENDING -> COMMITTED (kill=0) or KILLED (kill=1).
  - Commit to a slot that is not PENDING: ignored, err_o=1.
  - Commit to an absent id: ignored, err_o=1.
  - Commit in the same cycle as an accepted issue with the same id: applied to the newly allocated slot, which enters COMMITTED/KILLED directly.
- Retire: the matching slot goes FREE at the next edge.
  - Retire of a PENDING slot: still freed, err_o=1.
  - Retire of an absent id: ignored, err_o=1.
  - Retire and commit of the same id in the same cycle: slot freed, no error.
- Query: combinational lookup on query_id_i. Reflects registered state only; same-cycle commits are not forwarded.
- count_o: registered, updated as count + issue_fire - retire_hit (minus 0 on clear). Never wraps; simultaneous issue and retire leave it unchanged.
- err_o: registered; it pulses in the cycle after the offending event.
- Latency: an issue is visible to query_*, count_o and hazard checks one cycle after the handshake.

Test Plan:
- Reset then issue ids 1,2,3,4 (rd=0..3, we=1, no rs) on consecutive cycles -> count_o 1..4, full_o=1 after the 4th; id 5 sees issue_ready_o=0.
- RAW: id 1 rd=2 outstanding; offer id 2 with rs0=2 used -> ready=0. Retire id 1 -> ready=1 exactly one cycle later.
- Commit id 3 kill=1 in the same cycle as its issue -> next cycle query_id=3 gives killed=1, committed=0. Retire 3 -> count back to 0, err_o stays 0.
- Full table with retire id 1 and issue id 6 in the same cycle -> issue blocked (ready=0), count 4 -> 3. Next cycle id 6 is accepted into slot 0, count=4.
- Error cases: commit id 9 (absent), retire a PENDING id, double commit -> err_o pulses once per event. The PENDING slot is still freed.
- clear_i asserted with 3 slots occupied plus a same-cycle issue and commit -> count_o=0, empty_o=1, all queries 0 next cycle.

Source files
------------

// File: rtl/fir_xifu_scoreboard.sv
// rtl/fir_xifu_scoreboard.sv - outstanding XIF instruction scoreboard with issue hazard gating
// Ports:
//   clk_i, rst_i, clear_i               clock, sync active-high reset, sync flush of all slots
//   issue_valid_i / issue_ready_o       ID issue handshake
//   issue_id_i, issue_rd_i, issue_rd_we_i, issue_rs_i {rs1,rs0}, issue_rs_used_i
//   commit_valid_i, commit_id_i, commit_kill_i   XIF commit strobe
//   query_id_i -> query_committed_o, query_killed_o   EX lookup on registered state
//   retire_valid_i, retire_id_i         WB retire
//   count_o, full_o, empty_o            occupancy
//   err_o                               registered one-cycle protocol-error pulse
module fir_xifu_scoreboard #(
    parameter int NB_SLOTS = 4,
    parameter int ID_WIDTH = 4,
    parameter int NB_REGS  = 4,
    localparam int RW = $clog2(NB_REGS),
    localparam int CW = $clog2(NB_SLOTS + 1),
    localparam int SW = $clog2(NB_SLOTS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [RW-1:0]       issue_rd_i,
    input  logic                issue_rd_we_i,
    input  logic [2*RW-1:0]     issue_rs_i,
    input  logic [1:0]          issue_rs_used_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    input  logic [ID_WIDTH-1:0] query_id_i,
    output logic                query_committed_o,
    output logic                query_killed_o,
    input  logic                retire_valid_i,
    input  logic [ID_WIDTH-1:0] retire_id_i,
    output logic [CW-1:0]       count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        S_FREE      = 2'd0,
        S_PENDING   = 2'd1,
        S_COMMITTED = 2'd2,
        S_KILLED    = 2'd3
    } slot_state_e;

    slot_state_e         state_q [NB_SLOTS];
    slot_state_e         state_d [NB_SLOTS];
    logic [ID_WIDTH-1:0] id_q    [NB_SLOTS];
    logic [ID_WIDTH-1:0] id_d    [NB_SLOTS];
    logic [RW-1:0]       rd_q    [NB_SLOTS];
    logic [RW-1:0]       rd_d    [NB_SLOTS];
    logic                rd_we_q [NB_SLOTS];
    logic                rd_we_d [NB_SLOTS];
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    logic [RW-1:0] rs0, rs1;
    logic          full;
    logic          id_clash, raw_hazard, waw_hazard;
    logic          alloc_found;
    logic [SW-1:0] alloc_idx;
    logic          issue_fire, commit_new, commit_hit, retire_hit, same_cr;

    assign rs0  = issue_rs_i[RW-1:0];
    assign rs1  = issue_rs_i[2*RW-1:RW];
    assign full = (count_q == CW'(NB_SLOTS));

    // Hazard scan and lowest-free-slot search, all on start-of-cycle state.
    always_comb begin
        id_clash    = 1'b0;
        raw_hazard  = 1'b0;
        waw_hazard  = 1'b0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (state_q[i] != S_FREE) begin
                if (id_q[i] == issue_id_i) id_clash = 1'b1;
                if (rd_we_q[i]) begin
                    if (issue_rs_used_i[0] && rd_q[i] == rs0) raw_hazard = 1'b1;
                    if (issue_rs_used_i[1] && rd_q[i] == rs1) raw_hazard = 1'b1;
                    if (issue_rd_we_i && rd_q[i] == issue_rd_i) waw_hazard = 1'b1;
                end
            end else if (!alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = SW'(i);
            end
        end
    end

    assign issue_ready_o = !full && !id_clash && !raw_hazard && !waw_hazard;
    assign issue_fire    = issue_valid_i && issue_ready_o;

    always_comb begin
        query_committed_o = 1'b0;
        query_killed_o    = 1'b0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (state_q[i] != S_FREE && id_q[i] == query_id_i) begin
                if (state_q[i] == S_COMMITTED) query_committed_o = 1'b1;
                if (state_q[i] == S_KILLED)    query_killed_o    = 1'b1;
            end
        end
    end

    // A commit and retire of the same id in one cycle is a legal fast path:
    // the slot is simply freed and neither side flags an error.
    assign same_cr    = commit_valid_i && retire_valid_i && (commit_id_i == retire_id_i);
    // Ids are unique among live slots, so a commit matching the id being
    // issued can only target the slot allocated this cycle.
    assign commit_new = issue_fire && commit_valid_i && (commit_id_i == issue_id_i);

    always_comb begin
        commit_hit = 1'b0;
        retire_hit = 1'b0;
        err_d      = 1'b0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            rd_d[i]    = rd_q[i];
            rd_we_d[i] = rd_we_q[i];
        end

        for (int i = 0; i < NB_SLOTS; i++) begin
            if (state_q[i] != S_FREE) begin
                if (commit_valid_i && id_q[i] == commit_id_i) begin
                    commit_hit = 1'b1;
                    if (state_q[i] == S_PENDING)
                        state_d[i] = commit_kill_i ? S_KILLED : S_COMMITTED;
                    else if (!same_cr)
                        err_d = 1'b1;
                end
                // Retire is evaluated after commit so freeing wins.
                if (retire_valid_i && id_q[i] == retire_id_i) begin
                    retire_hit = 1'b1;
                    state_d[i] = S_FREE;
                    if (state_q[i] == S_PENDING && !same_cr) err_d = 1'b1;
                end
            end
        end

        if (issue_fire) begin
            state_d[alloc_idx] = commit_new ? (commit_kill_i ? S_KILLED : S_COMMITTED) : S_PENDING;
            id_d[alloc_idx]    = issue_id_i;
            rd_d[alloc_idx]    = issue_rd_i;
            rd_we_d[alloc_idx] = issue_rd_we_i;
        end

        if (commit_valid_i && !commit_hit && !commit_new) err_d = 1'b1;
        if (retire_valid_i && !retire_hit) err_d = 1'b1;

        count_d = count_q + {{(CW-1){1'b0}}, issue_fire} - {{(CW-1){1'b0}}, retire_hit};

        if (clear_i) begin
            for (int i = 0; i < NB_SLOTS; i++) state_d[i] = S_FREE;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_SLOTS; i++) begin
                state_q[i] <= S_FREE;
                id_q[i]    <= '0;
                rd_q[i]    <= '0;
                rd_we_q[i] <= 1'b0;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NB_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                rd_q[i]    <= rd_d[i];
                rd_we_q[i] <= rd_we_d[i];
            end
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = (count_q == '0);
    assign err_o   = err_q;

endmodule
